// File: rtl/bsg_manycore_pkg.sv
// Shared types for the manycore run sequencer: run-state encoding and the
// timestamped print_stat entry.
`define DECLARE_BSG_MANYCORE_STAT_ENTRY_S(tag_width_mp, cycle_width_mp) \
  typedef struct packed { \
    logic [tag_width_mp-1:0]   tag; \
    logic [cycle_width_mp-1:0] cycle; \
  } bsg_manycore_stat_entry_s

package bsg_manycore_pkg;

  typedef enum logic [2:0] {
    eReset      = 3'd0,
    eTagWait    = 3'd1,
    eRstRelease = 3'd2,
    eLoad       = 3'd3,
    eRun        = 3'd4,
    eDone       = 3'd5,
    eTimeout    = 3'd6
  } bsg_manycore_run_state_e;

  // LOAD and RUN together form the run phase: counting, stats and finish apply.
  function automatic logic bsg_manycore_run_active(input bsg_manycore_run_state_e s);
    return (s == eLoad) || (s == eRun);
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based FIFO with valid/ready enqueue and valid/yumi dequeue.
// els_p must be a power of two; pointers carry one wrap bit to tell full from empty.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);
  localparam int ptr_width_lp = $clog2(els_p);

  logic [width_p-1:0]    mem_q [els_p];
  logic [ptr_width_lp:0] wptr_q, rptr_q;
  logic                  full, empty;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[ptr_width_lp] != rptr_q[ptr_width_lp])
                && (wptr_q[ptr_width_lp-1:0] == rptr_q[ptr_width_lp-1:0]);
  assign ready_o = ~full;
  assign v_o     = ~empty;
  assign data_o  = mem_q[rptr_q[ptr_width_lp-1:0]];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (v_i)    wptr_q <= wptr_q + 1'b1;
      if (yumi_i) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (v_i) mem_q[wptr_q[ptr_width_lp-1:0]] <= data_i;
  end
endmodule

// File: rtl/bsg_manycore_run_sequencer.sv
// Sequences a manycore run: tag wait, delayed core reset release, load, run,
// then finish or watchdog timeout; timestamps print_stat events into a FIFO.
module bsg_manycore_run_sequencer
  import bsg_manycore_pkg::*;
#(
  parameter int reset_depth_p   = 3,
  parameter int data_width_p    = 32,
  parameter int timeout_width_p = 32,
  parameter int stat_els_p      = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       tag_done_i,
  input  logic                       loader_done_i,
  input  logic                       finish_v_i,
  input  logic [data_width_p-1:0]    finish_id_i,
  input  logic                       print_stat_v_i,
  input  logic [data_width_p-1:0]    print_stat_tag_i,
  input  logic [timeout_width_p-1:0] timeout_cycles_i,
  output logic                       core_reset_o,
  output logic                       loader_en_o,
  output logic [2:0]                 state_o,
  output logic [timeout_width_p-1:0] cycle_ctr_o,
  output logic                       stat_v_o,
  output logic [data_width_p-1:0]    stat_tag_o,
  output logic [timeout_width_p-1:0] stat_cycle_o,
  input  logic                       stat_yumi_i,
  output logic                       stat_overflow_o,
  output logic                       done_o,
  output logic                       timeout_o,
  output logic [data_width_p-1:0]    finish_id_o
);
  localparam int dcnt_width_lp = (reset_depth_p > 1) ? $clog2(reset_depth_p) : 1;
  localparam logic [dcnt_width_lp-1:0] dcnt_init_lp = dcnt_width_lp'(reset_depth_p - 1);

  `DECLARE_BSG_MANYCORE_STAT_ENTRY_S(data_width_p, timeout_width_p);

  bsg_manycore_run_state_e    state_q, state_d;
  logic [dcnt_width_lp-1:0]   dcnt_q, dcnt_d;
  logic [timeout_width_p-1:0] cycle_ctr_q, cycle_ctr_d;
  logic [data_width_p-1:0]    finish_id_q, finish_id_d;
  logic                       overflow_q, overflow_d;
  logic                       active, fifo_ready, fifo_v, enq, deq;
  bsg_manycore_stat_entry_s   enq_entry, head_entry;

  assign active = bsg_manycore_run_active(state_q);

  // Finish outranks the watchdog, which outranks the loader handshake.
  always_comb begin
    state_d     = state_q;
    dcnt_d      = dcnt_q;
    cycle_ctr_d = cycle_ctr_q;
    finish_id_d = finish_id_q;
    case (state_q)
      eReset:   state_d = eTagWait;
      eTagWait: begin
        if (tag_done_i) begin
          state_d = eRstRelease;
          dcnt_d  = dcnt_init_lp;
        end
      end
      eRstRelease: begin
        if (!tag_done_i) begin
          state_d = eTagWait;
        end else if (dcnt_q == '0) begin
          state_d     = eLoad;
          cycle_ctr_d = '0;
        end else begin
          dcnt_d = dcnt_q - 1'b1;
        end
      end
      eLoad, eRun: begin
        if (cycle_ctr_q != '1) cycle_ctr_d = cycle_ctr_q + 1'b1;
        if (finish_v_i) begin
          state_d     = eDone;
          finish_id_d = finish_id_i;
        end else if ((timeout_cycles_i != '0) && (cycle_ctr_q == timeout_cycles_i)) begin
          state_d = eTimeout;
        end else if ((state_q == eLoad) && loader_done_i) begin
          state_d = eRun;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= eReset;
      dcnt_q      <= '0;
      cycle_ctr_q <= '0;
      finish_id_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      dcnt_q      <= dcnt_d;
      cycle_ctr_q <= cycle_ctr_d;
      finish_id_q <= finish_id_d;
      overflow_q  <= overflow_d;
    end
  end

  // Fullness is sampled before any same-cycle dequeue frees a slot.
  assign enq        = active & print_stat_v_i & fifo_ready;
  assign deq        = stat_yumi_i & fifo_v & (state_q != eReset);
  assign overflow_d = overflow_q | (active & print_stat_v_i & ~fifo_ready);
  assign enq_entry  = '{tag: print_stat_tag_i, cycle: cycle_ctr_q};

  bsg_fifo_1r1w_small #(
    .width_p (data_width_p + timeout_width_p),
    .els_p   (stat_els_p)
  ) stat_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (enq),
    .ready_o (fifo_ready),
    .data_i  (enq_entry),
    .v_o     (fifo_v),
    .data_o  (head_entry),
    .yumi_i  (deq)
  );

  assign state_o         = state_q;
  assign core_reset_o    = (state_q == eReset) || (state_q == eTagWait) || (state_q == eRstRelease);
  assign loader_en_o     = (state_q == eLoad);
  assign cycle_ctr_o     = cycle_ctr_q;
  assign stat_v_o        = fifo_v;
  assign stat_tag_o      = head_entry.tag;
  assign stat_cycle_o    = head_entry.cycle;
  assign stat_overflow_o = overflow_q;
  assign done_o          = (state_q == eDone);
  assign timeout_o       = (state_q == eTimeout);
  assign finish_id_o     = finish_id_q;
endmodule

// File: tb/tb_bsg_manycore_run_sequencer.sv
// Self-checking bench: directed run scenarios plus randomized traffic, all
// compared every cycle against a queue-based behavioural model.
module tb_bsg_manycore_run_sequencer;
  localparam int DEPTH = 3;
  localparam int ELS   = 4;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        tag_done_i = 1'b0, loader_done_i = 1'b0, finish_v_i = 1'b0;
  logic        print_stat_v_i = 1'b0, stat_yumi_i = 1'b0;
  logic [31:0] finish_id_i = '0, print_stat_tag_i = '0, timeout_cycles_i = '0;
  logic        core_reset_o, loader_en_o, stat_v_o, stat_overflow_o, done_o, timeout_o;
  logic [2:0]  state_o;
  logic [31:0] cycle_ctr_o, stat_tag_o, stat_cycle_o, finish_id_o;

  bsg_manycore_run_sequencer #(
    .reset_depth_p(DEPTH), .data_width_p(32), .timeout_width_p(32), .stat_els_p(ELS)
  ) dut (
    .clk_i(clk_i), .reset_i(reset_i), .tag_done_i(tag_done_i), .loader_done_i(loader_done_i),
    .finish_v_i(finish_v_i), .finish_id_i(finish_id_i), .print_stat_v_i(print_stat_v_i),
    .print_stat_tag_i(print_stat_tag_i), .timeout_cycles_i(timeout_cycles_i),
    .core_reset_o(core_reset_o), .loader_en_o(loader_en_o), .state_o(state_o),
    .cycle_ctr_o(cycle_ctr_o), .stat_v_o(stat_v_o), .stat_tag_o(stat_tag_o),
    .stat_cycle_o(stat_cycle_o), .stat_yumi_i(stat_yumi_i), .stat_overflow_o(stat_overflow_o),
    .done_o(done_o), .timeout_o(timeout_o), .finish_id_o(finish_id_o)
  );

  always #5 clk_i = ~clk_i;

  int nChecks = 0;
  int nFails  = 0;
  bit checking = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phase number, consecutive tag_done streak, stat queue.
  typedef struct { logic [31:0] tag; logic [31:0] cyc; } statEntry_t;
  statEntry_t  mQ[$];
  int          mState = 0;
  int          mStreak = 0;
  logic [31:0] mCtr = '0;
  logic [31:0] mFinishId = '0;
  bit          mOverflow = 0;

  task automatic modelStep();
    bit          running = (mState == 3) || (mState == 4);
    bit          wasFull = (mQ.size() == ELS);
    logic [31:0] oldCtr  = mCtr;
    if (mState != 0 && stat_yumi_i && mQ.size() > 0) void'(mQ.pop_front());
    if (running && print_stat_v_i) begin
      if (wasFull) mOverflow = 1;
      else mQ.push_back('{tag: print_stat_tag_i, cyc: oldCtr});
    end
    case (mState)
      0: mState = 1;
      1, 2: begin
        mStreak = tag_done_i ? mStreak + 1 : 0;
        if (mStreak == 0) mState = 1;
        else if (mStreak > DEPTH) begin mState = 3; mCtr = '0; end
        else mState = 2;
      end
      3, 4: begin
        if (mCtr != 32'hFFFF_FFFF) mCtr = mCtr + 32'd1;
        if (finish_v_i) begin mState = 5; mFinishId = finish_id_i; end
        else if (timeout_cycles_i != 0 && oldCtr == timeout_cycles_i) mState = 6;
        else if (mState == 3 && loader_done_i) mState = 4;
      end
      default: ;
    endcase
  endtask

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mState = 0; mStreak = 0; mCtr = '0; mFinishId = '0; mOverflow = 0; mQ.delete();
    end else begin
      modelStep();
    end
  end

  always @(negedge clk_i) begin
    if (checking) begin
      checkOutput("state", 64'(state_o), 64'(mState));
      checkOutput("core_reset", 64'(core_reset_o), 64'(mState < 3));
      checkOutput("loader_en", 64'(loader_en_o), 64'(mState == 3));
      checkOutput("cycle_ctr", 64'(cycle_ctr_o), 64'(mCtr));
      checkOutput("stat_v", 64'(stat_v_o), 64'(mQ.size() > 0));
      checkOutput("overflow", 64'(stat_overflow_o), 64'(mOverflow));
      checkOutput("done", 64'(done_o), 64'(mState == 5));
      checkOutput("timeout", 64'(timeout_o), 64'(mState == 6));
      checkOutput("finish_id", 64'(finish_id_o), 64'(mFinishId));
      if (mQ.size() > 0) begin
        checkOutput("stat_tag", 64'(stat_tag_o), 64'(mQ[0].tag));
        checkOutput("stat_cycle", 64'(stat_cycle_o), 64'(mQ[0].cyc));
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input bit tag, input bit ldone, input bit fin, input logic [31:0] fid,
                               input bit ps, input logic [31:0] ptag, input bit yumi);
    tag_done_i = tag; loader_done_i = ldone; finish_v_i = fin; finish_id_i = fid;
    print_stat_v_i = ps; print_stat_tag_i = ptag; stat_yumi_i = yumi;
  endtask

  task automatic doReset(input logic [31:0] tmo);
    reset_i = 1'b1;
    applyStimulus(0, 0, 0, '0, 0, '0, 0);
    timeout_cycles_i = tmo;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  // From reset deasserted to the first LOAD cycle with tag_done held high.
  task automatic bringUp();
    tick();
    applyStimulus(1, 0, 0, '0, 0, '0, 0);
    repeat (DEPTH + 1) tick();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int terminalCnt = 0;

    // Reset held 5 cycles, then release timing with tag_done held.
    repeat (5) tick();
    checking = 1;
    checkOutput("rst_core_reset", 64'(core_reset_o), 64'd1);
    checkOutput("rst_state", 64'(state_o), 64'd0);
    checkOutput("rst_stat_v", 64'(stat_v_o), 64'd0);
    reset_i = 1'b0;
    tick();
    checkOutput("rel_tagwait", 64'(state_o), 64'd1);
    repeat (3) tick();
    applyStimulus(1, 0, 0, '0, 0, '0, 0);
    tick();
    checkOutput("rel_state_e1", 64'(state_o), 64'd2);
    tick();
    tick();
    checkOutput("rel_core_reset_e3", 64'(core_reset_o), 64'd1);
    tick();
    checkOutput("rel_core_reset_e4", 64'(core_reset_o), 64'd0);
    checkOutput("rel_state_load", 64'(state_o), 64'd3);
    checkOutput("rel_ctr0", 64'(cycle_ctr_o), 64'd0);
    tick();
    checkOutput("rel_ctr1", 64'(cycle_ctr_o), 64'd1);
    tick();
    checkOutput("rel_ctr2", 64'(cycle_ctr_o), 64'd2);

    // Single-cycle tag glitch restarts the full delay.
    doReset('0);
    tick();
    applyStimulus(1, 0, 0, '0, 0, '0, 0);
    tick();
    applyStimulus(0, 0, 0, '0, 0, '0, 0);
    tick();
    checkOutput("glitch_state", 64'(state_o), 64'd1);
    checkOutput("glitch_core_reset", 64'(core_reset_o), 64'd1);
    applyStimulus(1, 0, 0, '0, 0, '0, 0);
    repeat (3) tick();
    checkOutput("glitch_hold", 64'(core_reset_o), 64'd1);
    tick();
    checkOutput("glitch_load", 64'(state_o), 64'd3);

    // Normal finish: loader done 20 cycles in, finish at cycle 50.
    repeat (20) tick();
    applyStimulus(1, 1, 0, '0, 0, '0, 0);
    tick();
    checkOutput("fin_run", 64'(state_o), 64'd4);
    applyStimulus(1, 0, 0, '0, 0, '0, 0);
    repeat (29) tick();
    checkOutput("fin_ctr50", 64'(cycle_ctr_o), 64'd50);
    applyStimulus(1, 0, 1, 32'h1234, 0, '0, 0);
    tick();
    checkOutput("fin_done", 64'(done_o), 64'd1);
    checkOutput("fin_id", 64'(finish_id_o), 64'h1234);
    checkOutput("fin_ctr51", 64'(cycle_ctr_o), 64'd51);
    applyStimulus(1, 0, 1, 32'hBEEF, 0, '0, 0);
    tick();
    tick();
    checkOutput("fin_id_hold", 64'(finish_id_o), 64'h1234);
    checkOutput("fin_ctr_frozen", 64'(cycle_ctr_o), 64'd51);

    // Watchdog at 100 cycles, then finish colliding with it.
    doReset(32'd100);
    bringUp();
    applyStimulus(1, 1, 0, '0, 0, '0, 0);
    tick();
    applyStimulus(1, 0, 0, '0, 0, '0, 0);
    repeat (99) tick();
    checkOutput("to_ctr100", 64'(cycle_ctr_o), 64'd100);
    checkOutput("to_not_yet", 64'(timeout_o), 64'd0);
    tick();
    checkOutput("to_fired", 64'(timeout_o), 64'd1);
    checkOutput("to_state", 64'(state_o), 64'd6);
    checkOutput("to_ctr101", 64'(cycle_ctr_o), 64'd101);
    doReset(32'd100);
    bringUp();
    repeat (100) tick();
    applyStimulus(1, 0, 1, 32'h55, 0, '0, 0);
    tick();
    checkOutput("tie_done", 64'(done_o), 64'd1);
    checkOutput("tie_timeout", 64'(timeout_o), 64'd0);

    // Stat FIFO: five events into four slots, then drain.
    doReset('0);
    bringUp();
    repeat (3) tick();
    for (int k = 1; k <= 5; k++) begin
      applyStimulus(1, 0, 0, '0, 1, 32'(k), 0);
      tick();
    end
    applyStimulus(1, 0, 0, '0, 0, '0, 0);
    checkOutput("fifo_overflow", 64'(stat_overflow_o), 64'd1);
    for (int k = 1; k <= 4; k++) begin
      checkOutput("fifo_drain_tag", 64'(stat_tag_o), 64'(k));
      checkOutput("fifo_drain_cycle", 64'(stat_cycle_o), 64'(k + 2));
      applyStimulus(1, 0, 0, '0, 0, '0, 1);
      tick();
    end
    applyStimulus(1, 0, 0, '0, 0, '0, 0);
    checkOutput("fifo_empty", 64'(stat_v_o), 64'd0);

    // Asynchronous reset mid-run with two entries and overflow set.
    doReset('0);
    bringUp();
    applyStimulus(1, 1, 0, '0, 0, '0, 0);
    tick();
    for (int k = 0; k < 5; k++) begin
      applyStimulus(1, 0, 0, '0, 1, 32'(k + 10), 0);
      tick();
    end
    applyStimulus(1, 0, 0, '0, 0, '0, 1);
    tick();
    tick();
    applyStimulus(1, 0, 0, '0, 0, '0, 0);
    checkOutput("mid_pre_v", 64'(stat_v_o), 64'd1);
    checkOutput("mid_pre_ovf", 64'(stat_overflow_o), 64'd1);
    reset_i = 1'b1;
    #1;
    checkOutput("mid_core_reset", 64'(core_reset_o), 64'd1);
    checkOutput("mid_state", 64'(state_o), 64'd0);
    checkOutput("mid_stat_v", 64'(stat_v_o), 64'd0);
    checkOutput("mid_ovf", 64'(stat_overflow_o), 64'd0);
    tick();
    reset_i = 1'b0;

    // Randomized traffic, occasional resets and varying watchdog limits.
    doReset(32'($urandom_range(10, 120)));
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (mState >= 5) terminalCnt++;
      if (terminalCnt > 15 || $urandom_range(0, 499) == 0) begin
        terminalCnt = 0;
        doReset(($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(10, 120)));
        continue;
      end
      applyStimulus($urandom_range(0, 99) < 88, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 149) == 0, $urandom,
                    $urandom_range(0, 2) == 0, $urandom,
                    (mQ.size() > 0) && ($urandom_range(0, 1) == 1));
      tick();
    end

    checking = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end
endmodule
